// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word memory between fetch (I) and load/store (D).
// Ports: clk/rst, I and D request/response handshakes, memory address/write/read.
module mem_arbiter #(
  parameter int N      = 32,
  parameter int LENGTH = 512,
  parameter int WIDTH  = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_req_valid,
  output logic         i_req_ready,
  input  logic [N-1:0] i_req_addr,
  output logic         i_resp_valid,
  input  logic         i_resp_ready,
  output logic [N-1:0] i_resp_data,
  output logic         i_resp_err,
  input  logic         d_req_valid,
  output logic         d_req_ready,
  input  logic [N-1:0] d_req_addr,
  input  logic         d_req_we,
  input  logic [N-1:0] d_req_wdata,
  output logic         d_resp_valid,
  input  logic         d_resp_ready,
  output logic [N-1:0] d_resp_data,
  output logic         d_resp_err,
  output logic [N-1:0] mem_addr,
  output logic         mem_we,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef struct packed {
    logic         port_d;
    logic [N-1:0] addr;
    logic         we;
    logic [N-1:0] wdata;
    logic         err;
  } txn_t;

  state_t       state, state_nx;
  txn_t         txn;
  logic         last_d;
  logic [N-1:0] resp_data;
  logic         resp_err;

  logic         sel_i, sel_d, acc;
  logic [N-1:0] req_addr;
  logic         req_err;
  logic         hit;
  logic         own_i, own_d;
  logic         resp_done;

  always_comb begin
    state_nx     = state;
    sel_i        = 1'b0;
    sel_d        = 1'b0;
    i_req_ready  = 1'b0;
    d_req_ready  = 1'b0;
    acc          = 1'b0;
    req_addr     = '0;
    req_err      = 1'b0;
    hit          = 1'b0;
    mem_addr     = '0;
    mem_we       = 1'b0;
    mem_wdata    = '0;
    own_i        = 1'b0;
    own_d        = 1'b0;
    i_resp_valid = 1'b0;
    d_resp_valid = 1'b0;
    i_resp_data  = '0;
    d_resp_data  = '0;
    i_resp_err   = 1'b0;
    d_resp_err   = 1'b0;
    resp_done    = 1'b0;

    // On a tie the port granted last time loses.
    sel_i = i_req_valid & (~d_req_valid | last_d);
    sel_d = d_req_valid & (~i_req_valid | ~last_d);

    req_addr = sel_d ? d_req_addr : i_req_addr;
    req_err  = (|req_addr[1:0]) | (|req_addr[N-1:WIDTH+2]);

    hit = (state == ACCESS) & ~txn.err;
    if (hit) begin
      mem_addr  = txn.addr;
      mem_we    = txn.we;
      mem_wdata = txn.wdata;
    end

    own_i = (state == RESP) & ~txn.port_d;
    own_d = (state == RESP) & txn.port_d;
    i_resp_valid = own_i;
    d_resp_valid = own_d;
    if (own_i) begin
      i_resp_data = resp_data;
      i_resp_err  = resp_err;
    end
    if (own_d) begin
      d_resp_data = resp_data;
      d_resp_err  = resp_err;
    end
    resp_done = (own_i & i_resp_ready) | (own_d & d_resp_ready);

    unique case (state)
      IDLE: begin
        i_req_ready = sel_i;
        d_req_ready = sel_d;
        acc         = sel_i | sel_d;
        if (acc) state_nx = ACCESS;
      end
      ACCESS: state_nx = RESP;
      RESP: if (resp_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      txn       <= '0;
      last_d    <= 1'b1;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      state <= state_nx;
      if (acc) begin
        txn.port_d <= sel_d;
        txn.addr   <= req_addr;
        txn.we     <= sel_d & d_req_we;
        txn.wdata  <= sel_d ? d_req_wdata : '0;
        txn.err    <= req_err;
        last_d     <= sel_d;
      end
      if (state == ACCESS) begin
        resp_data <= (txn.err | txn.we) ? '0 : mem_rdata;
        resp_err  <= txn.err;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter.
// Word memory model is driven by the DUT's memory port.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid, i_req_ready;
  logic [31:0] i_req_addr;
  logic        i_resp_valid, i_resp_ready;
  logic [31:0] i_resp_data;
  logic        i_resp_err;
  logic        d_req_valid, d_req_ready;
  logic [31:0] d_req_addr;
  logic        d_req_we;
  logic [31:0] d_req_wdata;
  logic        d_resp_valid, d_resp_ready;
  logic [31:0] d_resp_data;
  logic        d_resp_err;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mem_arbiter #(.N(32), .LENGTH(512), .WIDTH(9)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready),
    .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_ready(i_resp_ready),
    .i_resp_data(i_resp_data), .i_resp_err(i_resp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready),
    .d_req_addr(d_req_addr), .d_req_we(d_req_we),
    .d_req_wdata(d_req_wdata),
    .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready),
    .d_resp_data(d_resp_data), .d_resp_err(d_resp_err),
    .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:511];
  int          we_cnt = 0;
  int          cyc = 0;

  assign mem_rdata = mem[mem_addr[10:2]];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (mem_we) begin
      mem[mem_addr[10:2]] = mem_wdata;
      we_cnt = we_cnt + 1;
    end
  end

  typedef struct {
    bit          d;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:11] != 21'd0);
  endfunction

  task automatic pop_cmp(input bit is_d, input string tag);
    exp_t e;
    chk({tag, " queue_nonempty"}, 32'(q.size() != 0), 32'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({tag, " port"}, 32'(is_d), 32'(e.d));
      chk({tag, " data"}, is_d ? d_resp_data : i_resp_data, e.data);
      chk({tag, " err"}, 32'(is_d ? d_resp_err : i_resp_err), 32'(e.err));
    end
  endtask

  task automatic do_txn(input bit is_d, input logic [31:0] addr,
                        input bit we, input logic [31:0] wd,
                        input logic [31:0] exp_data, input string tag);
    logic e;
    int   w0;
    e  = addr_err(addr);
    w0 = we_cnt;
    i_resp_ready = 1'b1;
    d_resp_ready = 1'b1;
    if (is_d) begin
      d_req_valid = 1'b1;
      d_req_addr  = addr;
      d_req_we    = we;
      d_req_wdata = wd;
    end else begin
      i_req_valid = 1'b1;
      i_req_addr  = addr;
    end
    #1;
    chk({tag, " req_ready"},
        32'(is_d ? d_req_ready : i_req_ready), 32'd1);
    q.push_back('{is_d, exp_data, e});
    tick();
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    d_req_addr  = 32'hFFFF_FFFF;
    i_req_addr  = 32'hFFFF_FFFF;
    chk({tag, " mem_addr"}, mem_addr, e ? 32'd0 : addr);
    chk({tag, " mem_we"}, 32'(mem_we), 32'(!e && we));
    if (we && !e) chk({tag, " mem_wdata"}, mem_wdata, wd);
    chk({tag, " no_early_resp"}, 32'(i_resp_valid | d_resp_valid), 32'd0);
    tick();
    chk({tag, " resp_valid"},
        32'(is_d ? d_resp_valid : i_resp_valid), 32'd1);
    chk({tag, " other_valid"},
        32'(is_d ? i_resp_valid : d_resp_valid), 32'd0);
    pop_cmp(is_d, tag);
    tick();
    chk({tag, " we_count"}, 32'(we_cnt - w0), 32'(!e && we));
    chk({tag, " back_idle"}, 32'(i_resp_valid | d_resp_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int gport[$];
  int gcyc[$];

  initial begin
    for (int k = 0; k < 512; k++) mem[k] = 32'd0;
    mem[5] = 32'hDEAD_BEEF;
    rst = 1'b1;
    i_req_valid = 1'b0; i_req_addr = '0; i_resp_ready = 1'b0;
    d_req_valid = 1'b0; d_req_addr = '0; d_req_we = 1'b0;
    d_req_wdata = '0; d_resp_ready = 1'b0;
    do_reset();

    chk("rst i_req_ready", 32'(i_req_ready), 32'd0);
    chk("rst d_req_ready", 32'(d_req_ready), 32'd0);
    chk("rst resp_valid", 32'(i_resp_valid | d_resp_valid), 32'd0);
    chk("rst i_resp_data", i_resp_data, 32'd0);
    chk("rst d_resp_data", d_resp_data, 32'd0);
    chk("rst resp_err", 32'(i_resp_err | d_resp_err), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);

    do_txn(1'b0, 32'h14, 1'b0, 32'd0, 32'hDEAD_BEEF, "iread");
    do_txn(1'b1, 32'h40, 1'b1, 32'h1234_5678, 32'd0, "store");
    chk("store mem", mem[16], 32'h1234_5678);
    do_txn(1'b1, 32'h40, 1'b0, 32'd0, 32'h1234_5678, "load");
    do_txn(1'b1, 32'h42, 1'b1, 32'hCAFE_F00D, 32'd0, "misalign");
    chk("misalign mem", mem[16], 32'h1234_5678);
    do_txn(1'b0, 32'h800, 1'b0, 32'd0, 32'd0, "oob");

    // Last grant was I; the reset must restore the D pointer.
    do_reset();
    chk("q empty pre-contention", 32'(q.size()), 32'd0);
    i_req_valid = 1'b1; i_req_addr = 32'h14;
    d_req_valid = 1'b1; d_req_addr = 32'h40;
    d_req_we = 1'b0; d_req_wdata = 32'd0;
    i_resp_ready = 1'b1; d_resp_ready = 1'b1;
    #1;
    for (int c = 0; c < 12; c++) begin
      if (i_resp_valid) pop_cmp(1'b0, "cont_i");
      if (d_resp_valid) pop_cmp(1'b1, "cont_d");
      if (i_req_ready) begin
        gport.push_back(0); gcyc.push_back(c);
        q.push_back('{1'b0, 32'hDEAD_BEEF, 1'b0});
      end
      if (d_req_ready) begin
        gport.push_back(1); gcyc.push_back(c);
        q.push_back('{1'b1, 32'h1234_5678, 1'b0});
      end
      tick();
    end
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    chk("cont grants", 32'(gport.size()), 32'd4);
    for (int g = 0; g < 4; g++) begin
      if (g < gport.size()) begin
        chk($sformatf("cont port%0d", g), 32'(gport[g]), 32'(g % 2));
        chk($sformatf("cont cyc%0d", g), 32'(gcyc[g]), 32'(3 * g));
      end
    end
    chk("cont q drained", 32'(q.size()), 32'd0);

    d_req_valid = 1'b1; d_req_addr = 32'h40; d_req_we = 1'b0;
    d_resp_ready = 1'b0;
    #1;
    chk("bp d_req_ready", 32'(d_req_ready), 32'd1);
    q.push_back('{1'b1, 32'h1234_5678, 1'b0});
    tick();
    d_req_valid = 1'b0;
    tick();
    i_req_valid = 1'b1; i_req_addr = 32'h14; i_resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp d_resp_valid", 32'(d_resp_valid), 32'd1);
      chk("bp d_resp_data", d_resp_data, 32'h1234_5678);
      chk("bp i_req_ready", 32'(i_req_ready), 32'd0);
      tick();
    end
    d_resp_ready = 1'b1;
    #1;
    pop_cmp(1'b1, "bp_d");
    tick();
    chk("bp i accepted", 32'(i_req_ready), 32'd1);
    chk("bp d released", 32'(d_resp_valid), 32'd0);
    q.push_back('{1'b0, 32'hDEAD_BEEF, 1'b0});
    tick();
    i_req_valid = 1'b0;
    tick();
    chk("bp i_resp_valid", 32'(i_resp_valid), 32'd1);
    pop_cmp(1'b0, "bp_i");
    tick();

    d_req_valid = 1'b1; d_req_addr = 32'h80;
    d_req_we = 1'b1; d_req_wdata = 32'hAAAA_5555;
    #1;
    chk("rmid d_req_ready", 32'(d_req_ready), 32'd1);
    tick();
    d_req_valid = 1'b0; d_req_we = 1'b0;
    chk("rmid access we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rmid mem_we", 32'(mem_we), 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("rmid no resp", 32'(i_resp_valid | d_resp_valid), 32'd0);
      chk("rmid mem_addr", mem_addr, 32'd0);
      tick();
    end
    i_req_valid = 1'b1; d_req_valid = 1'b1;
    #1;
    chk("rmid tie i", 32'(i_req_ready), 32'd1);
    chk("rmid tie d", 32'(d_req_ready), 32'd0);
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
